mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Multi-cycle load/store engine for the RISC-V core; sits between execute and the register file.
- Takes one memory request per handshake and drives a single-outstanding word-addressed data bus.
- Performs byte-lane steering, byte-enable generation and sign/zero extension.
- Returns load results to the register file's second write port (rdmau/rdmau_en/data_mau_in) via wb_rd/wb_en/wb_data.

Parameters:
TIMEOUT_CYCLES, 255, bus cycles in BUS state without mem_ack before a timeout fault (1..65535).

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept request (high only in IDLE)
req_store  in  1  1=store, 0=load
req_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  32  byte address
req_wdata  in  32  store data (low bits significant)
req_rd  in  5  load destination register
mem_req  out  1  bus request, held until mem_ack
mem_we  out  1  bus write
mem_addr  out  32  word address ({addr[31:2],2'b00})
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_ack  in  1  bus completion, single-cycle pulse
mem_rdata  in  32  read data, valid with mem_ack
wb_en  out  1  register write strobe (to rdmau_en)
wb_rd  out  5  destination (to rdmau)
wb_data  out  32  extended load value (to data_mau_in)
done  out  1  one-cycle completion pulse
fault  out  1  one-cycle fault pulse
fault_cause  out  2  00 none, 01 misaligned, 10 illegal funct3, 11 bus timeout; held until next fault

Behaviour:
- Reset (async, reset=0): state IDLE; mem_req, mem_we, wb_en, done, fault = 0; mem_addr, mem_be, mem_wdata, wb_rd, wb_data = 0; fault_cause = 00; timeout counter = 0. req_ready=1 after reset.
- req_ready is combinational: 1 iff state==IDLE. Acceptance = req_valid & req_ready at a rising clk edge; all req_* fields are latched at acceptance.
- Legal funct3: loads 000, 001, 010, 100, 101; stores 000, 001, 010. Anything else is illegal (cause 10).
- Misalignment check runs only when funct3 is legal: half (001/101) with addr[0]=1, or word (010) with addr[1:0]!=0 (cause 01).
- Illegal or misaligned request: fault=1 and fault_cause updated in cycle T+1; no bus activity; state remains IDLE.
- Legal request (accepted at edge T): enter BUS; mem_req=1 from T+1 with mem_we=req_store, mem_addr, mem_be and mem_wdata stable until ack.
- Store lanes, with o=addr[1:0]:
  - SB: be=1<<o, wdata={4{d[7:0]}}
  - SH: be=4'b0011 (o=0) or 4'b1100 (o=2), wdata={2{d[15:0]}}
  - SW: be=4'b1111, wdata=d
- Loads drive mem_be=4'b1111.
- BUS state: timeout counter increments each cycle mem_ack=0.
  - mem_ack=1 at edge A: mem_req drops at A+1.
  - Store: done=1 at A+1, return to IDLE.
  - Load: extract the lane selected by o, sign-extend (B/H) or zero-extend (BU/HU/W), register into wb_data; go to WB.
  - Counter reaches TIMEOUT_CYCLES with no ack: mem_req drops; fault=1 with cause 11 next cycle; return to IDLE; a late mem_ack in IDLE is ignored.
- WB state (one cycle, = A+1): done=1; wb_rd=latched rd; wb_en=1 unless rd==0 (wb_en=0, done still 1). Next cycle IDLE, so req_ready=1 at A+2.
- Latency: load accepted at T with ack at the first bus cycle gives wb_en at T+2; a store gives done at T+2. Minimum throughput is one request per 3 cycles.
- wb_data and wb_rd hold their values after wb_en drops; consumers must qualify with wb_en.
- Reset asserted mid-transaction aborts immediately: mem_req=0, no writeback, no done pulse.
- mem_ack outside BUS state is ignored.

Test Plan:
- LW addr=0x100, rd=5, mem_rdata=0xDEADBEEF with ack on first bus cycle -> mem_addr=0x100, be=1111, we=0; wb_en=1, wb_rd=5, wb_data=0xDEADBEEF two cycles after acceptance; done=1 in the same cycle.
- LB addr=0x103 with rdata=0x80112233 -> wb_data=0xFFFFFF80; LBU with the same stimulus -> 0x00000080; LHU addr=0x102 -> 0x00008011.
- SB addr=0x202, wdata=0x000000A5 -> mem_we=1, mem_addr=0x200, be=0100, mem_wdata=0xA5A5A5A5; done after ack; no wb_en.
- LW addr=0x101 -> fault=1, cause=01, mem_req never asserts; store funct3=100 -> fault, cause=10; req_ready stays 1.
- TIMEOUT_CYCLES=4 with no mem_ack -> mem_req high for 4 cycles then low; fault=1, cause=11; a later stray ack produces no wb_en.
- LW with rd=0 -> done=1, wb_en=0. Separately, reset pulsed while mem_req=1 -> all outputs 0 immediately; req_ready=1 after reset release.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store engine: accepts one request per handshake, drives a single-outstanding
// word bus, steers byte lanes and returns extended load data to the register file.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_WB
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_store;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [4:0]  r_rd;
    logic [15:0] r_cnt;

    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;
    logic        r_wb_en;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_done;
    logic        r_fault;
    logic [1:0]  r_fault_cause;

    logic        w_accept;
    logic        w_legal;
    logic        w_misal;
    logic        w_go;
    logic        w_timeout;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;

    assign req_ready   = (r_state == S_IDLE);
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_be      = r_mem_be;
    assign mem_wdata   = r_mem_wdata;
    assign wb_en       = r_wb_en;
    assign wb_rd       = r_wb_rd;
    assign wb_data     = r_wb_data;
    assign done        = r_done;
    assign fault       = r_fault;
    assign fault_cause = r_fault_cause;

    assign w_accept  = req_valid && (r_state == S_IDLE);
    assign w_go      = w_accept && w_legal && !w_misal;
    assign w_timeout = (r_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_legal = 1'b0;
        w_misal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = !req_store;
            default:                w_legal = 1'b0;
        endcase
        if ((req_funct3 == 3'b001) || (req_funct3 == 3'b101))
            w_misal = req_addr[0];
        else if (req_funct3 == 3'b010)
            w_misal = (req_addr[1:0] != 2'b00);
    end

    always_comb begin
        w_st_be    = 4'b1111;
        w_st_wdata = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                w_st_be    = 4'b0001 << req_addr[1:0];
                w_st_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_st_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_st_be    = 4'b1111;
                w_st_wdata = req_wdata;
            end
        endcase
    end

    always_comb begin
        w_byte    = mem_rdata[7:0];
        w_half    = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_ld_data = mem_rdata;
        case (r_off)
            2'b00:   w_byte = mem_rdata[7:0];
            2'b01:   w_byte = mem_rdata[15:8];
            2'b10:   w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_data = {24'd0, w_byte};
            3'b101:  w_ld_data = {16'd0, w_half};
            default: w_ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_go) w_next = S_BUS;
            S_BUS: begin
                if (mem_ack)
                    w_next = r_store ? S_IDLE : S_WB;
                else if (w_timeout)
                    w_next = S_IDLE;
            end
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_store       <= 1'b0;
            r_funct3      <= '0;
            r_off         <= '0;
            r_rd          <= '0;
            r_cnt         <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_be      <= '0;
            r_mem_wdata   <= '0;
            r_wb_en       <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_data     <= '0;
            r_done        <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_cause <= '0;
        end else begin
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            r_wb_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (!w_legal) begin
                            r_fault       <= 1'b1;
                            r_fault_cause <= 2'b10;
                        end else if (w_misal) begin
                            r_fault       <= 1'b1;
                            r_fault_cause <= 2'b01;
                        end else begin
                            r_store     <= req_store;
                            r_funct3    <= req_funct3;
                            r_off       <= req_addr[1:0];
                            r_rd        <= req_rd;
                            r_cnt       <= '0;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= req_store;
                            r_mem_addr  <= {req_addr[31:2], 2'b00};
                            r_mem_be    <= req_store ? w_st_be : 4'b1111;
                            r_mem_wdata <= req_store ? w_st_wdata : '0;
                        end
                    end
                end
                S_BUS: begin
                    // Ack wins over a timeout landing on the same edge.
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_done    <= 1'b1;
                        if (!r_store) begin
                            r_wb_data <= w_ld_data;
                            r_wb_rd   <= r_rd;
                            r_wb_en   <= (r_rd != 5'd0);
                        end
                    end else if (w_timeout) begin
                        r_mem_req     <= 1'b0;
                        r_fault       <= 1'b1;
                        r_fault_cause <= 2'b11;
                        r_cnt         <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed table-driven bench for mem_access_unit plus hand-written sequences
// for timeout, delayed ack, sticky fault cause and mid-transaction reset.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        done;
    logic        fault;
    logic [1:0]  fault_cause;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .done(done), .fault(fault), .fault_cause(fault_cause)
    );

    typedef struct {
        logic        store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        exp_fault;
        logic [1:0]  exp_cause;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_wb_en;
        logic [31:0] exp_wb_data;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd);
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        req_rd     = rd;
        chk("req_ready_before", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        issue(v.store, v.f3, v.addr, v.wdata, v.rd);
        if (v.exp_fault) begin
            chk("fault", 32'(fault), 32'd1);
            chk("fault_cause", 32'(fault_cause), 32'(v.exp_cause));
            chk("fault_mem_req", 32'(mem_req), 32'd0);
            chk("fault_ready", 32'(req_ready), 32'd1);
            @(negedge clk);
            chk("fault_pulse_end", 32'(fault), 32'd0);
            chk("fault_mem_req2", 32'(mem_req), 32'd0);
        end else begin
            chk("mem_req", 32'(mem_req), 32'd1);
            chk("mem_we", 32'(mem_we), 32'(v.store));
            chk("mem_addr", mem_addr, v.exp_addr);
            chk("mem_be", 32'(mem_be), 32'(v.exp_be));
            if (v.store) chk("mem_wdata", mem_wdata, v.exp_wdata);
            chk("busy_ready", 32'(req_ready), 32'd0);
            mem_ack   = 1'b1;
            mem_rdata = v.rdata;
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            chk("done", 32'(done), 32'd1);
            chk("mem_req_drop", 32'(mem_req), 32'd0);
            chk("wb_en", 32'(wb_en), 32'(v.exp_wb_en));
            if (v.exp_wb_en) begin
                chk("wb_rd", 32'(wb_rd), 32'(v.rd));
                chk("wb_data", wb_data, v.exp_wb_data);
            end
            chk("fault_none", 32'(fault), 32'd0);
            @(negedge clk);
            chk("done_end", 32'(done), 32'd0);
            chk("wb_en_end", 32'(wb_en), 32'd0);
            chk("ready_again", 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        st   f3      addr          wdata         rd     rdata         flt  cause  exp_addr      be       exp_wdata     wben  wb_data
        vecs[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,        5'd5,  32'hDEADBEEF, 1'b0, 2'b00, 32'h100, 4'b1111, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,        5'd6,  32'h80112233, 1'b0, 2'b00, 32'h100, 4'b1111, 32'h0,        1'b1, 32'hFFFFFF80};
        vecs[2]  = '{1'b0, 3'b100, 32'h103, 32'h0,        5'd7,  32'h80112233, 1'b0, 2'b00, 32'h100, 4'b1111, 32'h0,        1'b1, 32'h00000080};
        vecs[3]  = '{1'b0, 3'b101, 32'h102, 32'h0,        5'd8,  32'h80112233, 1'b0, 2'b00, 32'h100, 4'b1111, 32'h0,        1'b1, 32'h00008011};
        vecs[4]  = '{1'b0, 3'b001, 32'h102, 32'h0,        5'd9,  32'h80112233, 1'b0, 2'b00, 32'h100, 4'b1111, 32'h0,        1'b1, 32'hFFFF8011};
        vecs[5]  = '{1'b0, 3'b000, 32'h100, 32'h0,        5'd31, 32'h80112233, 1'b0, 2'b00, 32'h100, 4'b1111, 32'h0,        1'b1, 32'h00000033};
        vecs[6]  = '{1'b1, 3'b000, 32'h202, 32'h000000A5, 5'd0,  32'h0,        1'b0, 2'b00, 32'h200, 4'b0100, 32'hA5A5A5A5, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 3'b001, 32'h206, 32'h1234ABCD, 5'd0,  32'h0,        1'b0, 2'b00, 32'h204, 4'b1100, 32'hABCDABCD, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 5'd0,  32'h0,        1'b0, 2'b00, 32'h300, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 3'b010, 32'h104, 32'h0,        5'd0,  32'h12345678, 1'b0, 2'b00, 32'h104, 4'b1111, 32'h0,        1'b0, 32'h0};
        vecs[10] = '{1'b0, 3'b010, 32'h101, 32'h0,        5'd3,  32'h0,        1'b1, 2'b01, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[11] = '{1'b1, 3'b100, 32'h100, 32'h0,        5'd0,  32'h0,        1'b1, 2'b10, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[12] = '{1'b0, 3'b011, 32'h100, 32'h0,        5'd3,  32'h0,        1'b1, 2'b10, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[13] = '{1'b0, 3'b001, 32'h101, 32'h0,        5'd3,  32'h0,        1'b1, 2'b01, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[14] = '{1'b1, 3'b101, 32'h101, 32'h0,        5'd0,  32'h0,        1'b1, 2'b10, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h0};

        reset = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #12;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_wb", {wb_en, done, fault, fault_cause, wb_rd, mem_be}, 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // Bus timeout: mem_req held exactly 4 cycles, then fault 11.
        issue(1'b0, 3'b010, 32'h400, 32'h0, 5'd4);
        for (int c = 0; c < 4; c++) begin
            chk("to_mem_req_high", 32'(mem_req), 32'd1);
            chk("to_no_fault_yet", 32'(fault), 32'd0);
            @(negedge clk);
        end
        chk("to_mem_req_low", 32'(mem_req), 32'd0);
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_cause", 32'(fault_cause), 32'd3);
        chk("to_ready", 32'(req_ready), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h55555555;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stray_wb_en", 32'(wb_en), 32'd0);
        chk("stray_done", 32'(done), 32'd0);
        chk("stray_mem_req", 32'(mem_req), 32'd0);

        // Ack on the last bus cycle before timeout wins; cause stays 11.
        issue(1'b0, 3'b010, 32'h500, 32'h0, 5'd12);
        for (int c = 0; c < 3; c++) begin
            chk("late_mem_req", 32'(mem_req), 32'd1);
            @(negedge clk);
        end
        chk("late_mem_req4", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_wb_en", 32'(wb_en), 32'd1);
        chk("late_wb_data", wb_data, 32'h0BADF00D);
        chk("late_wb_rd", 32'(wb_rd), 32'd12);
        chk("late_no_fault", 32'(fault), 32'd0);
        chk("cause_held", 32'(fault_cause), 32'd3);
        @(negedge clk);
        chk("wb_data_hold", wb_data, 32'h0BADF00D);
        chk("wb_rd_hold", 32'(wb_rd), 32'd12);

        // Reset while mem_req is high aborts at once.
        issue(1'b1, 3'b010, 32'h600, 32'h11223344, 5'd0);
        chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_outs", {wb_en, done, fault, fault_cause, mem_we, mem_be}, 32'h0);
        chk("mid_rst_addr", mem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_mem_req", 32'(mem_req), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
